// File: rtl/pll_lock_ctrl.sv
// PLL lock controller: measures CLK cycles per Ref_Clk period and walks
// IDLE -> SETTLE -> ACQUIRE -> LOCKED, with a sticky lock-loss flag.
module pll_lock_ctrl #(
    parameter int MULT     = 50,
    parameter int TOL      = 2,
    parameter int CNT_W    = 8,
    parameter int SETTLE   = 4,
    parameter int LOCK_N   = 4,
    parameter int UNLOCK_N = 2,
    parameter int TIMEOUT  = 200
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Ref_Clk,
    input  logic             pll_en,
    input  logic             clr_lost,
    output logic             locked,
    output logic             lock_lost,
    output logic [CNT_W-1:0] meas_count,
    output logic             meas_valid,
    output logic [1:0]       state
);

    localparam int SET_W  = $clog2(SETTLE + 1);
    localparam int GOOD_W = $clog2(LOCK_N + 1);
    localparam int BAD_W  = $clog2(UNLOCK_N + 1);

    localparam logic [CNT_W-1:0]  WIN_LO      = CNT_W'(MULT - TOL);
    localparam logic [CNT_W-1:0]  WIN_HI      = CNT_W'(MULT + TOL);
    localparam logic [CNT_W-1:0]  TMO         = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [SET_W-1:0]  SETTLE_LAST = SET_W'(SETTLE - 1);
    localparam logic [SET_W-1:0]  SET_MAX     = {SET_W{1'b1}};
    localparam logic [GOOD_W-1:0] GOOD_LAST   = GOOD_W'(LOCK_N - 1);
    localparam logic [GOOD_W-1:0] GOOD_MAX    = {GOOD_W{1'b1}};
    localparam logic [BAD_W-1:0]  BAD_LAST    = BAD_W'(UNLOCK_N - 1);
    localparam logic [BAD_W-1:0]  BAD_MAX     = {BAD_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_ACQUIRE = 2'd2,
        ST_LOCKED  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                ref_s1, ref_s2, ref_s3, ref_edge;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                first_q, first_d;
    logic [SET_W-1:0]    settle_q, settle_d;
    logic [GOOD_W-1:0]   good_q, good_d;
    logic [BAD_W-1:0]    bad_q, bad_d;
    logic                lost_d;
    logic                win_edge, win_tmo, win_valid, win_good;
    logic [CNT_W-1:0]    win_meas;

    // Ref_Clk is asynchronous: two sync flops, a delay flop and a registered edge pulse.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ref_s1   <= 1'b0;
            ref_s2   <= 1'b0;
            ref_s3   <= 1'b0;
            ref_edge <= 1'b0;
        end else begin
            ref_s1   <= Ref_Clk;
            ref_s2   <= ref_s1;
            ref_s3   <= ref_s2;
            ref_edge <= ref_s2 & ~ref_s3;
        end
    end

    // The first edge after leaving IDLE closes a partial period and yields no window.
    assign win_edge  = ref_edge && first_q;
    assign win_tmo   = !ref_edge && (cnt_q == TMO);
    assign win_valid = (state_q != ST_IDLE) && (win_edge || win_tmo);
    assign win_meas  = ref_edge ? cnt_q : TMO;
    assign win_good  = win_edge && (cnt_q >= WIN_LO) && (cnt_q <= WIN_HI);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        first_d  = first_q;
        settle_d = settle_q;
        good_d   = good_q;
        bad_d    = bad_q;
        lost_d   = lock_lost;

        if (clr_lost) lost_d = 1'b0;

        if (state_q == ST_IDLE)      cnt_d = '0;
        else if (ref_edge || win_tmo) cnt_d = CNT_W'(1);
        else if (cnt_q != CNT_MAX)   cnt_d = cnt_q + CNT_W'(1);

        if (ref_edge && (state_q != ST_IDLE)) first_d = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (pll_en) state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (ref_edge) begin
                    if (settle_q == SETTLE_LAST) begin
                        state_d = ST_ACQUIRE;
                        good_d  = '0;
                    end
                    if (settle_q != SET_MAX) settle_d = settle_q + SET_W'(1);
                end
            end
            ST_ACQUIRE: begin
                if (win_valid) begin
                    if (win_good) begin
                        if (good_q == GOOD_LAST) begin
                            state_d = ST_LOCKED;
                            bad_d   = '0;
                        end
                        if (good_q != GOOD_MAX) good_d = good_q + GOOD_W'(1);
                    end else begin
                        good_d = '0;
                    end
                end
            end
            ST_LOCKED: begin
                if (win_valid) begin
                    if (win_good) begin
                        bad_d = '0;
                    end else if (bad_q == BAD_LAST) begin
                        // Set beats a same-cycle clr_lost.
                        state_d = ST_ACQUIRE;
                        good_d  = '0;
                        bad_d   = '0;
                        lost_d  = 1'b1;
                    end else if (bad_q != BAD_MAX) begin
                        bad_d = bad_q + BAD_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (!pll_en) begin
            state_d  = ST_IDLE;
            cnt_d    = '0;
            first_d  = 1'b0;
            settle_d = '0;
            good_d   = '0;
            bad_d    = '0;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            first_q    <= 1'b0;
            settle_q   <= '0;
            good_q     <= '0;
            bad_q      <= '0;
            lock_lost  <= 1'b0;
            meas_count <= '0;
            meas_valid <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            first_q    <= first_d;
            settle_q   <= settle_d;
            good_q     <= good_d;
            bad_q      <= bad_d;
            lock_lost  <= lost_d;
            meas_valid <= win_valid;
            if (win_valid) meas_count <= win_meas;
        end
    end

    assign locked = (state_q == ST_LOCKED);
    assign state  = state_q;

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Directed bench for pll_lock_ctrl: Ref_Clk is driven as whole periods of
// a chosen CLK-cycle length and outputs are sampled on CLK falling edges.
module tb_pll_lock_ctrl;

    logic       CLK = 1'b0;
    logic       RST;
    logic       Ref_Clk;
    logic       pll_en;
    logic       clr_lost;
    logic       locked;
    logic       lock_lost;
    logic [7:0] meas_count;
    logic       meas_valid;
    logic [1:0] state;

    int n_cmp = 0;
    int n_bad = 0;
    int mv_cnt = 0;
    int mv_lat = -1;
    int cyc_rise = 0;

    pll_lock_ctrl dut (
        .CLK        (CLK),
        .RST        (RST),
        .Ref_Clk    (Ref_Clk),
        .pll_en     (pll_en),
        .clr_lost   (clr_lost),
        .locked     (locked),
        .lock_lost  (lock_lost),
        .meas_count (meas_count),
        .meas_valid (meas_valid),
        .state      (state)
    );

    always #5 CLK = ~CLK;

    // One CLK cycle: sample outputs on the falling edge, then drive Ref_Clk.
    task automatic tick(input logic ref_val);
        @(negedge CLK);
        cyc_rise++;
        if (meas_valid === 1'b1) begin
            mv_cnt++;
            mv_lat = cyc_rise;
        end
        if (ref_val && !Ref_Clk) cyc_rise = 0;
        Ref_Clk = ref_val;
    endtask

    // n reference periods, each exactly 'period' CLK cycles rise-to-rise.
    task automatic ref_periods(input int period, input int n);
        for (int p = 0; p < n; p++) begin
            tick(1'b1);
            for (int i = 0; i < period / 2 - 1; i++) tick(1'b1);
            for (int i = 0; i < period - period / 2; i++) tick(1'b0);
        end
    endtask

    task automatic restart();
        pll_en = 1'b0;
        tick(1'b0);
        tick(1'b0);
        pll_en = 1'b1;
        tick(1'b0);
    endtask

    task automatic clear_lost();
        clr_lost = 1'b1;
        tick(1'b0);
        clr_lost = 1'b0;
        tick(1'b0);
    endtask

    task automatic test_reset();
        RST = 1'b0; Ref_Clk = 1'b0; pll_en = 1'b0; clr_lost = 1'b0;
        repeat (3) @(negedge CLK);
        n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL reset_state: got %0d expected 0", state); end
        n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL reset_locked: got %b expected 0", locked); end
        n_cmp++; if (lock_lost !== 1'b0) begin n_bad++; $display("FAIL reset_lock_lost: got %b expected 0", lock_lost); end
        n_cmp++; if (meas_count !== 8'd0) begin n_bad++; $display("FAIL reset_meas_count: got %0d expected 0", meas_count); end
        n_cmp++; if (meas_valid !== 1'b0) begin n_bad++; $display("FAIL reset_meas_valid: got %b expected 0", meas_valid); end
        RST = 1'b1;
        tick(1'b0);
        n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL idle_hold: got %0d expected 0", state); end
    endtask

    task automatic test_lock_50();
        pll_en = 1'b1;
        tick(1'b0);
        n_cmp++; if (state !== 2'd1) begin n_bad++; $display("FAIL lock50_settle: got %0d expected 1", state); end
        tick(1'b0);
        mv_cnt = 0;
        ref_periods(50, 7);
        n_cmp++; if (state !== 2'd2) begin n_bad++; $display("FAIL lock50_acq_state: got %0d expected 2", state); end
        n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL lock50_acq_locked: got %b expected 0", locked); end
        n_cmp++; if (meas_count !== 8'd50) begin n_bad++; $display("FAIL lock50_meas: got %0d expected 50", meas_count); end
        n_cmp++; if (mv_lat !== 4) begin n_bad++; $display("FAIL lock50_valid_latency: got %0d expected 4", mv_lat); end
        n_cmp++; if (mv_cnt !== 6) begin n_bad++; $display("FAIL lock50_windows7: got %0d expected 6", mv_cnt); end
        ref_periods(50, 1);
        n_cmp++; if (state !== 2'd3) begin n_bad++; $display("FAIL lock50_locked_state: got %0d expected 3", state); end
        n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL lock50_locked: got %b expected 1", locked); end
        n_cmp++; if (mv_cnt !== 7) begin n_bad++; $display("FAIL lock50_windows8: got %0d expected 7", mv_cnt); end
    endtask

    task automatic test_tolerance();
        pll_en = 1'b0;
        tick(1'b0);
        n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL tol_disable: got %0d expected 0", state); end
        restart();
        ref_periods(52, 8);
        n_cmp++; if (state !== 2'd3) begin n_bad++; $display("FAIL tol_52_state: got %0d expected 3", state); end
        n_cmp++; if (meas_count !== 8'd52) begin n_bad++; $display("FAIL tol_52_meas: got %0d expected 52", meas_count); end
        restart();
        ref_periods(48, 8);
        n_cmp++; if (state !== 2'd3) begin n_bad++; $display("FAIL tol_48_state: got %0d expected 3", state); end
        restart();
        ref_periods(53, 12);
        n_cmp++; if (state !== 2'd2) begin n_bad++; $display("FAIL tol_53_state: got %0d expected 2", state); end
        n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL tol_53_locked: got %b expected 0", locked); end
        n_cmp++; if (meas_count !== 8'd53) begin n_bad++; $display("FAIL tol_53_meas: got %0d expected 53", meas_count); end
        restart();
        ref_periods(47, 12);
        n_cmp++; if (state !== 2'd2) begin n_bad++; $display("FAIL tol_47_state: got %0d expected 2", state); end
    endtask

    task automatic test_unlock();
        restart();
        ref_periods(50, 8);
        n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL unlock_prelock: got %b expected 1", locked); end
        ref_periods(60, 1);
        ref_periods(50, 3);
        n_cmp++; if (state !== 2'd3) begin n_bad++; $display("FAIL unlock_single_bad_state: got %0d expected 3", state); end
        n_cmp++; if (lock_lost !== 1'b0) begin n_bad++; $display("FAIL unlock_single_bad_lost: got %b expected 0", lock_lost); end
        ref_periods(60, 2);
        ref_periods(50, 1);
        n_cmp++; if (state !== 2'd2) begin n_bad++; $display("FAIL unlock_state: got %0d expected 2", state); end
        n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL unlock_locked: got %b expected 0", locked); end
        n_cmp++; if (lock_lost !== 1'b1) begin n_bad++; $display("FAIL unlock_lost: got %b expected 1", lock_lost); end
        n_cmp++; if (meas_count !== 8'd60) begin n_bad++; $display("FAIL unlock_meas: got %0d expected 60", meas_count); end
        clear_lost();
        n_cmp++; if (lock_lost !== 1'b0) begin n_bad++; $display("FAIL clr_lost: got %b expected 0", lock_lost); end
    endtask

    // clr_lost lands exactly in the cycle whose edge judges the 2nd bad window.
    task automatic test_set_clr_collision();
        restart();
        ref_periods(50, 8);
        ref_periods(60, 2);
        repeat (4) tick(1'b1);
        clr_lost = 1'b1;
        tick(1'b1);
        clr_lost = 1'b0;
        repeat (20) tick(1'b1);
        repeat (25) tick(1'b0);
        n_cmp++; if (state !== 2'd2) begin n_bad++; $display("FAIL collide_state: got %0d expected 2", state); end
        n_cmp++; if (lock_lost !== 1'b1) begin n_bad++; $display("FAIL collide_set_wins: got %b expected 1", lock_lost); end
        clear_lost();
    endtask

    task automatic test_timeout();
        restart();
        ref_periods(50, 8);
        n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL tmo_prelock: got %b expected 1", locked); end
        mv_cnt = 0;
        repeat (170) tick(1'b0);
        n_cmp++; if (meas_count !== 8'd200) begin n_bad++; $display("FAIL tmo1_meas: got %0d expected 200", meas_count); end
        n_cmp++; if (mv_cnt !== 1) begin n_bad++; $display("FAIL tmo1_windows: got %0d expected 1", mv_cnt); end
        n_cmp++; if (state !== 2'd3) begin n_bad++; $display("FAIL tmo1_state: got %0d expected 3", state); end
        n_cmp++; if (lock_lost !== 1'b0) begin n_bad++; $display("FAIL tmo1_lost: got %b expected 0", lock_lost); end
        repeat (200) tick(1'b0);
        n_cmp++; if (mv_cnt !== 2) begin n_bad++; $display("FAIL tmo2_windows: got %0d expected 2", mv_cnt); end
        n_cmp++; if (state !== 2'd2) begin n_bad++; $display("FAIL tmo2_state: got %0d expected 2", state); end
        n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL tmo2_locked: got %b expected 0", locked); end
        n_cmp++; if (lock_lost !== 1'b1) begin n_bad++; $display("FAIL tmo2_lost: got %b expected 1", lock_lost); end
    endtask

    task automatic test_disable_mid_acquire();
        restart();
        ref_periods(50, 7);
        n_cmp++; if (state !== 2'd2) begin n_bad++; $display("FAIL dis_pre_state: got %0d expected 2", state); end
        pll_en = 1'b0;
        tick(1'b0);
        n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL dis_idle: got %0d expected 0", state); end
        n_cmp++; if (lock_lost !== 1'b1) begin n_bad++; $display("FAIL dis_lost_kept: got %b expected 1", lock_lost); end
        pll_en = 1'b1;
        tick(1'b0);
        n_cmp++; if (state !== 2'd1) begin n_bad++; $display("FAIL dis_resettle: got %0d expected 1", state); end
        ref_periods(50, 7);
        n_cmp++; if (state !== 2'd2) begin n_bad++; $display("FAIL dis_reacq: got %0d expected 2", state); end
        ref_periods(50, 1);
        n_cmp++; if (state !== 2'd3) begin n_bad++; $display("FAIL dis_relock: got %0d expected 3", state); end
    endtask

    task automatic test_async_reset();
        tick(1'b0);
        #2 RST = 1'b0;
        #1;
        n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL arst_state: got %0d expected 0", state); end
        n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL arst_locked: got %b expected 0", locked); end
        n_cmp++; if (lock_lost !== 1'b0) begin n_bad++; $display("FAIL arst_lost: got %b expected 0", lock_lost); end
        n_cmp++; if (meas_count !== 8'd0) begin n_bad++; $display("FAIL arst_meas: got %0d expected 0", meas_count); end
        n_cmp++; if (meas_valid !== 1'b0) begin n_bad++; $display("FAIL arst_valid: got %b expected 0", meas_valid); end
        @(negedge CLK);
        RST = 1'b1;
        tick(1'b0);
    endtask

    initial begin
        test_reset();
        test_lock_50();
        test_tolerance();
        test_unlock();
        test_set_clr_collision();
        test_timeout();
        test_disable_mid_acquire();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
